// File: rtl/idex_pipeline_reg.sv
// -----------------------------------------------------------------------------
// idex_pipeline_reg
//
// ID/EX pipeline register for a 5-stage MIPS-style core, with the load-use
// hazard detector folded in. A load sitting in EX whose destination (Rt) is
// read by the instruction in ID forces a single-cycle stall. During that stall
// PC and IF/ID hold, and a bubble is clocked into EX.
//
// Optional feature: define IDEX_BUBBLE_COUNT_EN to add bubble_cnt_o. This is a
// saturating 16-bit count of bubbles caused by a hazard or by a flush.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   id_valid_i                   ID stage holds a real instruction
//   id_Rs_i/id_Rt_i/id_Rd_i      register specifiers decoded in ID
//   id_rs_data_i/id_rt_data_i    register-file read data
//   id_imm_i, id_pc4_i           sign-extended immediate, PC+4
//   id_ctrl_i[7:0]               RegWrite,MemtoReg,MemRead,MemWrite,
//                                ALUSrc,RegDst,ALUOp[1:0]
//   flush_i                      kill the instruction in ID
//   ex_*_o                       registered copies of the ID fields
//   bubble_cnt_o                 bubble counter (IDEX_BUBBLE_COUNT_EN only)
//   stall_o                      load-use hazard this cycle
//   pc_write_o, ifid_write_o     PC / IF-ID update enables
// -----------------------------------------------------------------------------
module idex_pipeline_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [4:0]        id_Rs_i,
   input  logic [4:0]        id_Rt_i,
   input  logic [4:0]        id_Rd_i,
   input  logic [DATA_W-1:0] id_rs_data_i,
   input  logic [DATA_W-1:0] id_rt_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [DATA_W-1:0] id_pc4_i,
   input  logic [7:0]        id_ctrl_i,
   input  logic              flush_i,
   output logic              ex_valid_o,
   output logic [4:0]        ex_Rs_o,
   output logic [4:0]        ex_Rt_o,
   output logic [4:0]        ex_Rd_o,
   output logic [DATA_W-1:0] ex_rs_data_o,
   output logic [DATA_W-1:0] ex_rt_data_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [DATA_W-1:0] ex_pc4_o,
   output logic [7:0]        ex_ctrl_o,
`ifdef IDEX_BUBBLE_COUNT_EN
   output logic [15:0]       bubble_cnt_o,
`endif
   output logic              stall_o,
   output logic              pc_write_o,
   output logic              ifid_write_o
);

   localparam int MEM_READ_BIT = 5;

   logic              valid_q,   valid_d;
   logic [4:0]        rs_q,      rs_d;
   logic [4:0]        rt_q,      rt_d;
   logic [4:0]        rd_q,      rd_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q,     imm_d;
   logic [DATA_W-1:0] pc4_q,     pc4_d;
   logic [7:0]        ctrl_q,    ctrl_d;

   logic hazard;
   logic bubble;

   // Load in EX whose destination is a source of the live instruction in ID.
   // A flush kills the consumer, so it cannot be stalled on. The rst_i term
   // keeps the stall low even while the reset is still propagating to the
   // registers.
   assign hazard = valid_q & ctrl_q[MEM_READ_BIT] & (rt_q != 5'd0)
                 & id_valid_i & ~flush_i
                 & ((rt_q == id_Rs_i) | (rt_q == id_Rt_i))
                 & ~rst_i;

   assign bubble = flush_i | hazard | ~id_valid_i;

   assign stall_o      = hazard;
   assign pc_write_o   = ~hazard;
   assign ifid_write_o = ~hazard;

   always_comb begin
      // NOTE: every _d gets a default before any condition, so no latch can be inferred.
      valid_d   = 1'b1;
      rs_d      = id_Rs_i;
      rt_d      = id_Rt_i;
      rd_d      = id_Rd_i;
      ctrl_d    = id_ctrl_i;
      // The datapath fields load even for a bubble. They are don't-care once
      // ctrl is zero, and an ungated load keeps their enable logic trivial.
      rs_data_d = id_rs_data_i;
      rt_data_d = id_rt_data_i;
      imm_d     = id_imm_i;
      pc4_d     = id_pc4_i;
      if (bubble) begin
         valid_d = 1'b0;
         rs_d    = 5'd0;
         rt_d    = 5'd0;
         rd_d    = 5'd0;
         ctrl_d  = 8'd0;
      end
   end

   // NOTE: datapath registers are reset as well, so every registered output reads 0 during reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q   <= 1'b0;
         rs_q      <= 5'd0;
         rt_q      <= 5'd0;
         rd_q      <= 5'd0;
         ctrl_q    <= 8'd0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc4_q     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         valid_q   <= valid_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         ctrl_q    <= ctrl_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         pc4_q     <= pc4_d;
      end
   end

   assign ex_valid_o   = valid_q;
   assign ex_Rs_o      = rs_q;
   assign ex_Rt_o      = rt_q;
   assign ex_Rd_o      = rd_q;
   assign ex_ctrl_o    = ctrl_q;
   assign ex_rs_data_o = rs_data_q;
   assign ex_rt_data_o = rt_data_q;
   assign ex_imm_o     = imm_q;
   assign ex_pc4_o     = pc4_q;

`ifdef IDEX_BUBBLE_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Idle slots (!id_valid_i alone) are not counted. Only bubbles forced by a
   // hazard or a flush increment the count.
   always_comb begin
      cnt_d = cnt_q;
      if ((hazard | flush_i) && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bubble_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_idex_pipeline_reg.sv
// -----------------------------------------------------------------------------
// Testbench for idex_pipeline_reg. A small model tracks what the EX slot must
// hold, and a compare process checks every output on each falling edge.
// Directed scenarios add literal expectations on top of the model.
// Inputs change 1 time unit after the falling edge. The model captures on the
// rising edge.
// -----------------------------------------------------------------------------
module tb_idex_pipeline_reg;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              id_valid = 1'b0;
   logic [4:0]        id_rs = '0, id_rt = '0, id_rd = '0;
   logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc4 = '0;
   logic [7:0]        id_ctrl = '0;
   logic              flush = 1'b0;

   logic              ex_valid;
   logic [4:0]        ex_rs, ex_rt, ex_rd;
   logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
   logic [7:0]        ex_ctrl;
   logic              stall, pc_write, ifid_write;
`ifdef IDEX_BUBBLE_COUNT_EN
   logic [15:0]       bubble_cnt;
`endif

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   idex_pipeline_reg #(.DATA_W(DATA_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .id_valid_i   (id_valid),
      .id_Rs_i      (id_rs),
      .id_Rt_i      (id_rt),
      .id_Rd_i      (id_rd),
      .id_rs_data_i (id_rs_data),
      .id_rt_data_i (id_rt_data),
      .id_imm_i     (id_imm),
      .id_pc4_i     (id_pc4),
      .id_ctrl_i    (id_ctrl),
      .flush_i      (flush),
      .ex_valid_o   (ex_valid),
      .ex_Rs_o      (ex_rs),
      .ex_Rt_o      (ex_rt),
      .ex_Rd_o      (ex_rd),
      .ex_rs_data_o (ex_rs_data),
      .ex_rt_data_o (ex_rt_data),
      .ex_imm_o     (ex_imm),
      .ex_pc4_o     (ex_pc4),
      .ex_ctrl_o    (ex_ctrl),
`ifdef IDEX_BUBBLE_COUNT_EN
      .bubble_cnt_o (bubble_cnt),
`endif
      .stall_o      (stall),
      .pc_write_o   (pc_write),
      .ifid_write_o (ifid_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the EX slot ----------------
   typedef struct {
      bit               valid;
      bit [4:0]         rs, rt, rd;
      bit [7:0]         ctrl;
      bit [DATA_W-1:0]  rs_data, rt_data, imm, pc4;
   } slot_t;

   slot_t   m = '{default: 0};
   int      m_cnt = 0;

   // A load (MemRead) in EX writing a non-zero register that the live,
   // unflushed ID instruction reads.
   function automatic bit model_stall();
      bit is_load, reads_it;
      is_load  = m.valid && m.ctrl[5] && (m.rt != 0);
      reads_it = (m.rt == id_rs) || (m.rt == id_rt);
      return !rst && is_load && reads_it && id_valid && !flush;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m     = '{default: 0};
         m_cnt = 0;
      end else begin
         bit st;
         st = model_stall();
         if ((st || flush) && m_cnt < 65535) m_cnt = m_cnt + 1;
         m.rs_data = id_rs_data;
         m.rt_data = id_rt_data;
         m.imm     = id_imm;
         m.pc4     = id_pc4;
         if (st || flush || !id_valid) begin
            m.valid = 0; m.rs = 0; m.rt = 0; m.rd = 0; m.ctrl = 0;
         end else begin
            m.valid = 1; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd; m.ctrl = id_ctrl;
         end
      end
   end

   // Compare process: outputs are settled and inputs stable at the falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("ex_valid",   ex_valid,   m.valid);
         check("ex_rs",      ex_rs,      m.rs);
         check("ex_rt",      ex_rt,      m.rt);
         check("ex_rd",      ex_rd,      m.rd);
         check("ex_ctrl",    ex_ctrl,    m.ctrl);
         check("ex_rs_data", ex_rs_data, m.rs_data);
         check("ex_rt_data", ex_rt_data, m.rt_data);
         check("ex_imm",     ex_imm,     m.imm);
         check("ex_pc4",     ex_pc4,     m.pc4);
         check("stall",      stall,      model_stall());
         check("pc_write",   pc_write,   !model_stall());
         check("ifid_write", ifid_write, !model_stall());
`ifdef IDEX_BUBBLE_COUNT_EN
         check("bubble_cnt", bubble_cnt, m_cnt[15:0]);
`endif
      end
   end

   // ---------------- stimulus ----------------
   int pc = 0;

   task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [7:0] ctrl, input bit fl,
                        input logic [DATA_W-1:0] rsd);
      @(negedge clk);
      #1;
      pc         = pc + 4;
      id_valid   = v;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = rd;
      id_ctrl    = ctrl;
      flush      = fl;
      id_rs_data = rsd;
      id_rt_data = rsd ^ 32'hA5A5_0000;
      id_imm     = 32'hFFFF_0000 | 32'(pc);
      id_pc4     = 32'(pc);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset
      #2;
      cmp_en = 1'b1;
      check("rst stall",    stall,    1'b0);
      check("rst pc_write", pc_write, 1'b1);
      check("rst ex_valid", ex_valid, 1'b0);
      check("rst ex_ctrl",  ex_ctrl,  8'h00);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;

      // Plain capture
      drive(1, 5'd0, 5'd0, 5'd5, 8'h84, 0, 32'h1234);
      after_edge();
      check("cap ex_valid",   ex_valid,   1'b1);
      check("cap ex_rd",      ex_rd,      5'd5);
      check("cap ex_ctrl",    ex_ctrl,    8'h84);
      check("cap ex_rs_data", ex_rs_data, 32'h1234);
      check("cap stall",      stall,      1'b0);

      // Load-use: load Rt=8, consumer Rs=8
      drive(1, 5'd1, 5'd8, 5'd0, 8'hE8, 0, 32'h11);
      drive(1, 5'd8, 5'd2, 5'd9, 8'h84, 0, 32'h22);
      #1;
      check("lu stall",      stall,      1'b1);
      check("lu pc_write",   pc_write,   1'b0);
      check("lu ifid_write", ifid_write, 1'b0);
      after_edge();
      check("lu bub valid",  ex_valid,   1'b0);
      check("lu bub ctrl",   ex_ctrl,    8'h00);
      check("lu bub regs",   {ex_rs, ex_rt, ex_rd}, 15'd0);
      check("lu bub data",   ex_rs_data, 32'h22);
      check("lu post stall", stall,      1'b0);
      drive(1, 5'd8, 5'd2, 5'd9, 8'h84, 0, 32'h22);  // consumer replayed
      after_edge();
      check("lu replay rs",  ex_rs,      5'd8);

      // Load to $zero never stalls
      drive(1, 5'd0, 5'd0, 5'd0, 8'hE8, 0, 32'h33);
      drive(1, 5'd0, 5'd4, 5'd6, 8'h84, 0, 32'h44);
      #1;
      check("zero stall",    stall,      1'b0);

      // Flush beats hazard
      drive(1, 5'd1, 5'd3, 5'd0, 8'hE8, 0, 32'h55);
      drive(1, 5'd4, 5'd3, 5'd7, 8'h84, 1, 32'h66);
      #1;
      check("fl stall",      stall,      1'b0);
      check("fl pc_write",   pc_write,   1'b1);
      after_edge();
      check("fl bub valid",  ex_valid,   1'b0);
      check("fl bub ctrl",   ex_ctrl,    8'h00);

      // Back-to-back dependent loads: each stalls once
      drive(1, 5'd1, 5'd10, 5'd0, 8'hE8, 0, 32'h77);
      drive(1, 5'd10, 5'd11, 5'd0, 8'hE8, 0, 32'h88);
      drive(1, 5'd10, 5'd11, 5'd0, 8'hE8, 0, 32'h88);
      drive(1, 5'd11, 5'd12, 5'd13, 8'h84, 0, 32'h99);
      #1;
      check("b2b 2nd stall", stall,      1'b1);
      drive(1, 5'd11, 5'd12, 5'd13, 8'h84, 0, 32'h99);
      #1;
      check("b2b released",  stall,      1'b0);

      // Idle slot: not a real instruction
      drive(0, 5'd3, 5'd3, 5'd3, 8'hFF, 0, 32'hAA);
      after_edge();
      check("idle valid",    ex_valid,   1'b0);

      // Async reset mid-stall
      drive(1, 5'd1, 5'd7, 5'd0, 8'hE8, 0, 32'hBB);
      drive(1, 5'd7, 5'd2, 5'd3, 8'h84, 0, 32'hCC);
      #1;
      check("ar stall pre",  stall,      1'b1);
      rst = 1'b1;
      #1;
      check("ar stall",      stall,      1'b0);
      check("ar ex_valid",   ex_valid,   1'b0);
      check("ar pc_write",   pc_write,   1'b1);
      #1 rst = 1'b0;

      // Short table of mixed vectors; the model checks every cycle
      for (int i = 0; i < 24; i++) begin
         drive(i % 7 != 6, 5'(i % 4), 5'((i + 1) % 4), 5'(i % 32),
               (i % 3 == 0) ? 8'hE8 : 8'h84, i % 9 == 8, 32'(i * 32'h101));
      end

`ifdef IDEX_BUBBLE_COUNT_EN
      // 3 hazards + 2 flushes from a fresh reset
      drive(0, 5'd0, 5'd0, 5'd0, 8'h00, 0, 32'h0);
      rst = 1'b1;
      #2 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1, 5'd0, 5'd9, 5'd0, 8'hE8, 0, 32'h1);
         drive(1, 5'd9, 5'd0, 5'd0, 8'h84, 0, 32'h2);
         drive(0, 5'd0, 5'd0, 5'd0, 8'h00, 0, 32'h0);
      end
      drive(1, 5'd0, 5'd0, 5'd0, 8'h84, 1, 32'h3);
      drive(1, 5'd0, 5'd0, 5'd0, 8'h84, 1, 32'h4);
      drive(0, 5'd0, 5'd0, 5'd0, 8'h00, 0, 32'h0);
      after_edge();
      check("cnt five",      bubble_cnt, 16'd5);
      // Drive the counter to its ceiling and beyond
      for (int k = 0; k < 65540; k++) begin
         drive(1, 5'd0, 5'd0, 5'd0, 8'h84, 1, 32'h5);
      end
      after_edge();
      check("cnt saturate",  bubble_cnt, 16'hFFFF);
`endif

      drive(0, 5'd0, 5'd0, 5'd0, 8'h00, 0, 32'h0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/idex_pipeline_reg.md
IDEX_PIPELINE_REG -- requirements
Module: idex_pipeline_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of all datapath fields.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 id_valid_i  input  1  SHALL indicate that the ID stage holds a real instruction.
REQ-005 id_Rs_i, id_Rt_i, id_Rd_i  input  5 each  SHALL carry the register specifiers decoded in ID.
REQ-006 id_rs_data_i, id_rt_data_i, id_imm_i, id_pc4_i  input  DATA_W each  SHALL carry the register-file reads, sign-extended immediate and PC+4.
REQ-007 id_ctrl_i  input  8  SHALL carry control bits: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite, [3] ALUSrc, [2] RegDst, [1:0] ALUOp.
REQ-008 flush_i  input  1  SHALL kill the instruction currently in ID (taken branch/jump).
REQ-009 ex_valid_o  output  1  SHALL mark the EX-stage slot as a real instruction.
REQ-010 ex_Rs_o, ex_Rt_o, ex_Rd_o  output  5 each  SHALL be the registered specifiers; ex_Rs_o/ex_Rt_o drive the forwarding unit's IDEX_Rs/IDEX_Rt.
REQ-011 ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o  output  DATA_W each  SHALL be the registered datapath fields.
REQ-012 ex_ctrl_o  output  8  SHALL be the registered control bits, same layout as id_ctrl_i.
REQ-013 stall_o  output  1  SHALL flag a load-use hazard in the current cycle.
REQ-014 pc_write_o, ifid_write_o  output  1 each  SHALL enable PC and IF/ID register updates.

Function
REQ-015 hazard SHALL be combinational: ex_valid_o & ex_ctrl_o[5] & (ex_Rt_o != 0) & id_valid_i & !flush_i & ((ex_Rt_o == id_Rs_i) | (ex_Rt_o == id_Rt_i)).
REQ-016 stall_o SHALL equal hazard; pc_write_o and ifid_write_o SHALL equal !hazard, all in the same cycle.
REQ-017 A bubble SHALL be loaded on a rising edge when flush_i | hazard | !id_valid_i.
REQ-018 A bubble SHALL load ex_valid_o=0, ex_ctrl_o=0 and ex_Rs_o=ex_Rt_o=ex_Rd_o=0.
REQ-019 A bubble SHALL still load the datapath fields from their inputs.
REQ-020 Otherwise every ex_* output SHALL capture its id_* input with ex_valid_o=1.
REQ-021 Capture latency SHALL be exactly one clock; no output other than stall_o/pc_write_o/ifid_write_o SHALL depend combinationally on inputs.
REQ-022 The hazard SHALL last exactly one cycle per load, because the inserted bubble clears ex_ctrl_o[5].
REQ-023 When flush_i and a would-be hazard coincide, flush SHALL win: bubble loaded, stall_o=0, write enables=1.
REQ-024 Back-to-back loads with dependent consumers SHALL each cause one independent stall cycle.

Reset
REQ-025 While rst_i is high, all registered outputs SHALL be 0, including the counter when it is present.
REQ-026 While rst_i is high, stall_o SHALL be 0 and pc_write_o=ifid_write_o SHALL be 1.
REQ-027 Reset asserted mid-stall SHALL clear the stall immediately, asynchronously.

Configuration
REQ-028 With macro IDEX_BUBBLE_COUNT_EN defined, output bubble_cnt_o (16 bits) SHALL be present.
REQ-029 bubble_cnt_o SHALL increment on each edge that loads a bubble due to hazard or flush_i (not !id_valid_i alone), saturating at 16'hFFFF.
REQ-030 Without IDEX_BUBBLE_COUNT_EN, the port and counter logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, then id_valid_i=1, id_Rd_i=5, id_ctrl_i=8'h84, id_rs_data_i=32'h1234 -> next cycle ex_valid_o=1, ex_Rd_o=5, ex_ctrl_o=8'h84, ex_rs_data_o=32'h1234, stall_o=0.
REQ-032 Load (ctrl=8'hE8, Rt=8) in EX, then ID Rs=8 -> stall_o=1 and pc_write_o=0 for one cycle; next EX slot is a bubble (ctrl=0, Rs/Rt/Rd=0); stall_o=0 afterwards.
REQ-033 Load with Rt=0 in EX, then ID Rs=0 -> stall_o never asserts.
REQ-034 Load Rt=3 in EX, ID Rt=3, flush_i=1 same cycle -> stall_o=0, bubble loaded, pc_write_o=1.
REQ-035 rst_i pulsed asynchronously while stall_o=1 -> stall_o=0 and ex_valid_o=0 before the next clock edge.
REQ-036 With IDEX_BUBBLE_COUNT_EN defined: 3 hazard stalls plus 2 flushes -> bubble_cnt_o=5; preload near 16'hFFFF -> holds at 16'hFFFF.
